// File: rtl/md_sequencer.sv
// md_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// One radix-2 step per cycle (32 steps), then a sign-fix cycle, then a
// one-cycle Done pulse. Divide-by-zero and signed overflow skip straight
// to DONE. Busy stalls the pipeline while an operation is in flight.
module md_sequencer (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        Start,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  // acc_q/lo_q form the 64-bit product when multiplying, and the
  // remainder/quotient pair when dividing.
  logic [31:0] acc_q, acc_d;
  logic [31:0] lo_q, lo_d;
  // Magnitude of the multiplicand or divisor.
  logic [31:0] opa_q, opa_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  // Request decode on the raw inputs.
  logic        op1_signed, op2_signed;
  logic        op1_neg, op2_neg;
  logic [31:0] op1_abs, op2_abs;
  logic        div_zero, div_ovf, bypass;
  logic [31:0] byp_res;
  logic        start_ok;

  assign op1_signed = (Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
                      (Funct3 == OP_DIV)  || (Funct3 == OP_REM);
  assign op2_signed = (Funct3 == OP_MULH) || (Funct3 == OP_DIV) ||
                      (Funct3 == OP_REM);
  assign op1_neg    = op1_signed & Operand1[31];
  assign op2_neg    = op2_signed & Operand2[31];
  assign op1_abs    = op1_neg ? (32'd0 - Operand1) : Operand1;
  assign op2_abs    = op2_neg ? (32'd0 - Operand2) : Operand2;

  assign div_zero = Funct3[2] & (Operand2 == 32'd0);
  assign div_ovf  = Funct3[2] & ~Funct3[0] &
                    (Operand1 == 32'h8000_0000) & (Operand2 == 32'hFFFF_FFFF);
  assign bypass   = div_zero | div_ovf;
  // Funct3[1] selects the remainder flavour within the divide group.
  assign byp_res  = div_zero ? (Funct3[1] ? Operand1 : 32'hFFFF_FFFF)
                             : (Funct3[1] ? 32'd0    : 32'h8000_0000);

  assign start_ok = Start & ~Flush & ((state_q == IDLE) || (state_q == DONE));

  // One shift-add multiply step: add the multiplicand into the upper half
  // when the current multiplier bit is set, then shift the pair right.
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : 33'd0);
  assign mul_nxt = {mul_sum, lo_q[31:1]};

  // One restoring divide step: shift the next dividend bit into the
  // partial remainder and subtract the divisor if it fits.
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [31:0] div_rem_nxt, div_quo_nxt;
  assign div_shift   = {acc_q, lo_q[31]};
  assign div_diff    = div_shift - {1'b0, opa_q};
  assign div_ge      = ~div_diff[32];
  assign div_rem_nxt = div_ge ? div_diff[31:0] : div_shift[31:0];
  assign div_quo_nxt = {lo_q[30:0], div_ge};

  // Sign correction applied in FIX.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? (64'd0 - {acc_q, lo_q}) : {acc_q, lo_q};
  assign quo_fix  = neg_res_q ? (32'd0 - lo_q) : lo_q;
  assign rem_fix  = neg_rem_q ? (32'd0 - acc_q) : acc_q;

  // Next-state, datapath update and output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opa_d     = opa_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    Busy      = 1'b0;
    Done      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        Done    = (state_q == DONE);
        Busy    = start_ok;
        state_d = IDLE;
        if (start_ok) begin
          f3_d      = Funct3;
          cnt_d     = 5'd31;
          acc_d     = 32'd0;
          lo_d      = Funct3[2] ? op1_abs : op2_abs;
          opa_d     = Funct3[2] ? op2_abs : op1_abs;
          neg_res_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          if (bypass) begin
            result_d = byp_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        Busy = 1'b1;
        if (f3_q[2]) begin
          acc_d = div_rem_nxt;
          lo_d  = div_quo_nxt;
        end else begin
          {acc_d, lo_d} = mul_nxt;
        end
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      FIX: begin
        Busy    = 1'b1;
        state_d = DONE;
        unique case (f3_q)
          OP_MUL:                      result_d = prod_fix[31:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[63:32];
          OP_DIV, OP_DIVU:             result_d = quo_fix;
          default:                     result_d = rem_fix;
        endcase
      end
      default: state_d = IDLE;
    endcase

    // Abort from the hazard logic: drop the operation, keep the old result.
    if (Flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  assign Result = result_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CPU_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (CPU_RST) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      f3_q      <= 3'd0;
      acc_q     <= 32'd0;
      lo_q      <= 32'd0;
      opa_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opa_q     <= opa_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Testbench for md_sequencer: scoreboard of expected results and latencies,
// one task per scenario, inputs driven and outputs sampled around negedge.
module tb_md_sequencer;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  always #5 CPU_CLK = ~CPU_CLK;

  md_sequencer dut (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST  (CPU_RST),
    .Start    (Start),
    .Funct3   (Funct3),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Flush    (Flush),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result)
  );

  // Reference model built on the simulator's own 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] ua64, ub64, p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    case (f)
      F_MUL:    begin p = ua64 * ub64; return p[31:0];  end
      F_MULH:   begin p = sa * sb;     return p[63:32]; end
      F_MULHSU: begin p = sa * ub;     return p[63:32]; end
      F_MULHU:  begin p = ua64 * ub64; return p[63:32]; end
      F_DIV:    begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      F_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F_REM:    begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default:  return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 1;
    if ((f == F_DIV || f == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 34;
  endfunction

  // Cycle 0: present the request and check that Busy rises at once.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input string name, input bit push);
    exp_t e;
    Funct3   = f;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    #1;
    n_vec++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_cycle0 got %b want 1", name, Busy);
    end
    if (push) begin
      e.res  = exp_res;
      e.lat  = exp_lat;
      e.name = name;
      sb_q.push_back(e);
    end
  endtask

  // Pop the oldest expectation and follow the DUT until Done, checking
  // Busy each cycle, the Done cycle number and the result.
  task automatic wait_done();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    e = sb_q.pop_front();
    for (int c = 1; c <= e.lat + 3 && !seen; c++) begin
      @(negedge CPU_CLK);
      if (c == 1) Start = 1'b0;
      #1;
      if (Done === 1'b1) begin
        seen = 1'b1;
        n_vec++;
        if (c != e.lat) begin
          n_err++;
          $display("FAIL %s done_cycle got %0d want %0d", e.name, c, e.lat);
        end
        n_vec++;
        if (Result !== e.res) begin
          n_err++;
          $display("FAIL %s result got %h want %h", e.name, Result, e.res);
        end
        n_vec++;
        if (Busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy_in_done got %b want 0", e.name, Busy);
        end
      end else begin
        n_vec++;
        if (Busy !== logic'(c < e.lat)) begin
          n_err++;
          $display("FAIL %s busy_cycle%0d got %b want %b", e.name, c, Busy,
                   logic'(c < e.lat));
        end
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s done_timeout got none want cycle %0d", e.name, e.lat);
    end
  endtask

  // Cycle after Done: pulse gone, idle, result held.
  task automatic check_quiet(input string name, input logic [31:0] exp_res);
    @(negedge CPU_CLK);
    #1;
    n_vec++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done got done=%b busy=%b want 0/0", name, Done, Busy);
    end
    n_vec++;
    if (Result !== exp_res) begin
      n_err++;
      $display("FAIL %s result_hold got %h want %h", name, Result, exp_res);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input string name);
    @(negedge CPU_CLK);
    start_op(f, a, b, exp_res, exp_lat, name, 1'b1);
    wait_done();
    check_quiet(name, exp_res);
  endtask

  task automatic test_reset();
    CPU_RST  = 1'b1;
    Start    = 1'b0;
    Flush    = 1'b0;
    Funct3   = 3'd0;
    Operand1 = 32'd0;
    Operand2 = 32'd0;
    repeat (3) @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    #1;
    n_vec++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b result=%h want 0/0/0",
               Busy, Done, Result);
    end
  endtask

  task automatic test_mul();
    run_op(F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7x-3");
    run_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
    run_op(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");
    run_op(F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, "mulhsu_-1x2");
  endtask

  task automatic test_div();
    run_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_-7/2");
    run_op(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_-7/2");
    run_op(F_DIVU, 32'd100,       32'd7, 32'd14,        34, "divu_100/7");
    run_op(F_REMU, 32'd100,       32'd7, 32'd2,         34, "remu_100/7");
  endtask

  task automatic test_bypass();
    run_op(F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
    run_op(F_REMU, 32'd5,         32'd0,         32'd5,         1, "remu_by0");
    run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    @(negedge CPU_CLK);
    prev = Result;
    start_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 34, "flush_div", 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge CPU_CLK);
      if (c == 1)  Start = 1'b0;
      if (c == 10) Flush = 1'b1;
      if (c == 11) Flush = 1'b0;
      #1;
      if (c == 11) begin
        n_vec++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
          n_err++;
          $display("FAIL flush_c11 got busy=%b done=%b want 0/0", Busy, Done);
        end
        n_vec++;
        if (Result !== prev) begin
          n_err++;
          $display("FAIL flush_result got %h want %h", Result, prev);
        end
      end
    end
    // Cycle 12: new request accepted, so Done lands in cycle 46.
    @(negedge CPU_CLK);
    start_op(F_DIVU, 32'd100, 32'd7, 32'd14, 34, "after_flush", 1'b1);
    wait_done();
    check_quiet("after_flush", 32'd14);
    // Flush together with Start: the request must be refused.
    @(negedge CPU_CLK);
    Funct3 = F_MUL; Operand1 = 32'd3; Operand2 = 32'd3;
    Start = 1'b1; Flush = 1'b1;
    #1;
    n_vec++;
    if (Busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_busy got %b want 0", Busy);
    end
    @(negedge CPU_CLK);
    Start = 1'b0; Flush = 1'b0;
    #1;
    n_vec++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'd14) begin
      n_err++;
      $display("FAIL flush_start_refused got busy=%b done=%b result=%h want 0/0/%h",
               Busy, Done, Result, 32'd14);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    @(negedge CPU_CLK);
    start_op(F_MUL, 32'd7, 32'd9, 32'd63, 34, "rst_mul", 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge CPU_CLK);
      if (c == 1)  Start = 1'b0;
      if (c == 20) CPU_RST = 1'b1;
    end
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    #1;
    n_vec++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_c21 got busy=%b done=%b result=%h want 0/0/0",
               Busy, Done, Result);
    end
    for (int c = 22; c <= 60; c++) begin
      @(negedge CPU_CLK);
      #1;
      if (Done === 1'b1) done_seen++;
    end
    n_vec++;
    if (done_seen != 0) begin
      n_err++;
      $display("FAIL rst_mid_no_done got %0d pulses want 0", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge CPU_CLK);
    start_op(F_MUL, 32'd6, 32'd7, 32'd42, 34, "b2b_mul", 1'b1);
    wait_done();
    // Start in the Done cycle: second Done exactly 34 cycles later.
    start_op(F_DIVU, 32'd1000, 32'd9, 32'd111, 34, "b2b_divu", 1'b1);
    wait_done();
    start_op(F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "b2b_byp1", 1'b1);
    wait_done();
    start_op(F_REMU, 32'd5, 32'd0, 32'd5, 1, "b2b_byp2", 1'b1);
    wait_done();
    check_quiet("b2b_end", 32'd5);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = (i == 5) ? 32'd0 : $urandom();
      if (i == 6) b = b >> 20;
      run_op(3'(i), a, b, ref_op(3'(i), a, b), ref_lat(3'(i), a, b),
             $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_bypass();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have port CPU_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port CPU_RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port Start, input, 1 bit: EX-stage request to begin an RV32M operation.
REQ-004 SHALL have port Funct3, input, 3 bits: operation select, 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port Operand1, input, 32 bits: rs1 value (multiplicand or dividend).
REQ-006 SHALL have port Operand2, input, 32 bits: rs2 value (multiplier or divisor).
REQ-007 SHALL have port Flush, input, 1 bit: abort request from the hazard logic.
REQ-008 SHALL have port Busy, output, 1 bit: pipeline stall request.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 SHALL have port Result, output, 32 bits: operation result.

Function
REQ-011 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-012 Cycle numbering: cycle 0 SHALL be the cycle in which Start=1 is sampled in IDLE or DONE.
REQ-013 On Start in IDLE or DONE, SHALL latch Funct3 and the operands, take absolute values for signed operands (MULH: both; MULHSU: Operand1 only; DIV/REM: both), load a 5-bit counter with 31, and enter CALC.
REQ-014 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply (64-bit product), restoring shift-subtract for divide (32-bit quotient and 32-bit remainder).
REQ-015 The counter SHALL decrement each CALC cycle; at count 0 the next state SHALL be FIX (32 CALC cycles in total).
REQ-016 FIX SHALL apply the sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-017 FIX SHALL then select the result: MUL low 32 bits; MULH, MULHSU and MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder. The next state SHALL be DONE.
REQ-018 Normal-path latency: Done=1 and Result valid SHALL occur in cycle 34.
REQ-019 Divide by zero (Operand2=0, Funct3[2]=1) SHALL bypass CALC and FIX: quotient 0xFFFFFFFF, remainder = Operand1, Done in cycle 1.
REQ-020 Signed overflow (DIV/REM, Operand1=0x80000000, Operand2=0xFFFFFFFF) SHALL bypass CALC and FIX: quotient 0x80000000, remainder 0, Done in cycle 1.
REQ-021 Busy SHALL be combinational: Busy = (Start & (IDLE | DONE) & ~Flush) | CALC | FIX; Busy SHALL be 0 in the Done cycle.
REQ-022 Done SHALL be high only in the DONE state, and for exactly one cycle per operation.
REQ-023 DONE SHALL go to IDLE on the next edge unless Start is sampled, in which case the new operation starts (back-to-back operations).
REQ-024 Start SHALL be ignored in CALC and FIX.
REQ-025 Result SHALL hold its value until the next FIX or bypass update.
REQ-026 Flush in any state SHALL return the block to IDLE on the next edge with no Done and Result unchanged; Flush together with Start SHALL win (the request is not accepted).

Reset
REQ-027 With CPU_RST=1 at an edge, the block SHALL enter IDLE with counter=0, Busy=0, Done=0 and Result=0, regardless of state, Start or Flush.
REQ-028 Reset mid-operation SHALL discard the operation; no Done SHALL follow.

Verification
REQ-029 MUL 7 x 0xFFFFFFFD (-3): Busy high in cycles 0-33; Done in cycle 34 with Result=0xFFFFFFEB.
REQ-030 MULH 0x80000000 x 0x80000000: Result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF: Result=0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2: Result=0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2: Result=0xFFFFFFFD. REM on the same operands: Result=0xFFFFFFFF. DIVU 100 / 7: Result=14. REMU 100 / 7: Result=2.
REQ-032 DIVU 5/0: Done in cycle 1 with Result=0xFFFFFFFF. REMU 5/0: Result=5. DIV 0x80000000 / 0xFFFFFFFF: Result=0x80000000 in cycle 1. REM on the same operands: Result=0.
REQ-033 Flush in cycle 10 of a DIV: Busy=0 and state IDLE in cycle 11, no Done. A Start in cycle 12 SHALL be accepted and complete in cycle 46.
REQ-034 CPU_RST in cycle 20 of a MUL: in cycle 21 all outputs are 0, and no Done follows. A Start asserted in the Done cycle SHALL produce a second Done exactly 34 cycles later.
